// File: rtl/nap_countdown_timer_if.sv
// Command and display bundle between a keypad/controller and nap_countdown_timer.
// Strobes (load, start_stop, clear) are one-cycle pulses with no backpressure; outputs are always valid.
interface nap_countdown_timer_if;
    logic [3:0] ten_in;
    logic [3:0] one_in;
    logic       load;
    logic       start_stop;
    logic       clear;
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
    logic       running;
    logic       done;
    logic       done_pulse;
    logic [2:0] state_dbg;

    modport master (
        output ten_in, one_in, load, start_stop, clear,
        input  min_ten, min_one, sec_ten, sec_one, running, done, done_pulse, state_dbg
    );

    modport slave (
        input  ten_in, one_in, load, start_stop, clear,
        output min_ten, min_one, sec_ten, sec_one, running, done, done_pulse, state_dbg
    );
endinterface

// File: rtl/nap_countdown_timer.sv
// MM:SS countdown timer loaded from two BCD minute digits, ticking once per TICK_DIV clocks.
// Raises a level done flag and a one-cycle done_pulse when the count reaches 00:00.
module nap_countdown_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic CLK,
    input  logic RST,
    nap_countdown_timer_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_n;
    logic [3:0]    mt_q, mo_q, st_q, so_q;
    logic [3:0]    mt_n, mo_n, st_n, so_n;
    logic [PW-1:0] presc_q, presc_n;
    logic          done_q, done_n;
    logic          pulse_q, pulse_n;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_n;
            mt_q    <= mt_n;
            mo_q    <= mo_n;
            st_q    <= st_n;
            so_q    <= so_n;
            presc_q <= presc_n;
            done_q  <= done_n;
            pulse_q <= pulse_n;
        end
    end

    always_comb begin
        state_n = state_q;
        mt_n    = mt_q;
        mo_n    = mo_q;
        st_n    = st_q;
        so_n    = so_q;
        presc_n = presc_q;
        done_n  = done_q;
        pulse_n = 1'b0;

        if (bus.clear) begin
            state_n = IDLE;
            mt_n    = 4'd0;
            mo_n    = 4'd0;
            st_n    = 4'd0;
            so_n    = 4'd0;
            presc_n = '0;
            done_n  = 1'b0;
        end else if (bus.load) begin
            state_n = LOADED;
            mt_n    = clamp9(bus.ten_in);
            mo_n    = clamp9(bus.one_in);
            st_n    = 4'd0;
            so_n    = 4'd0;
            presc_n = '0;
            done_n  = 1'b0;
        end else if (bus.start_stop) begin
            // A start_stop coinciding with a tick wins: the prescaler simply holds.
            case (state_q)
                LOADED:  if ({mt_q, mo_q, st_q, so_q} != 16'h0000) state_n = RUN;
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = state_q;
            endcase
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_n = '0;
                if ({mt_q, mo_q, st_q, so_q} != 16'h0000) begin
                    if (so_q != 4'd0) begin
                        so_n = so_q - 4'd1;
                    end else begin
                        so_n = 4'd9;
                        if (st_q != 4'd0) begin
                            st_n = st_q - 4'd1;
                        end else begin
                            st_n = 4'd5;
                            if (mo_q != 4'd0) begin
                                mo_n = mo_q - 4'd1;
                            end else begin
                                mo_n = 4'd9;
                                mt_n = mt_q - 4'd1;
                            end
                        end
                    end
                end
                if ({mt_n, mo_n, st_n, so_n} == 16'h0000) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    pulse_n = 1'b1;
                end
            end else begin
                presc_n = presc_q + 1'b1;
            end
        end
    end

    assign bus.min_ten    = mt_q;
    assign bus.min_one    = mo_q;
    assign bus.sec_ten    = st_q;
    assign bus.sec_one    = so_q;
    assign bus.running    = (state_q == RUN);
    assign bus.done       = done_q;
    assign bus.done_pulse = pulse_q;
    assign bus.state_dbg  = state_q;
endmodule
